prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
Parametrised, registered priority encoder. It accepts an N-bit request vector and produces the winning index plus a one-hot grant, with a valid/ready output handshake. It supports two modes: fixed priority (MSB highest) and round-robin (rotating priority). It is the sequential, width-generic successor to the combinational 8x3 encoder and sits in front of shared-resource arbitration logic.

Parameters:
N, 8, number of request lines; must be >= 2.
W, $clog2(N), index width; derived, not to be overridden.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous, active-low reset.
enable_i  input  1  capture enable; 0 blocks new captures only.
mode_i  input  1  0 = fixed priority (index N-1 highest); 1 = round-robin.
req_i  input  N  request vector; bit k = request from source k.
ready_i  input  1  consumer accepts the current output.
valid_o  output  1  idx_o/onehot_o hold a valid grant.
idx_o  output  W  index of the granted request.
onehot_o  output  N  one-hot grant; equals 1 << idx_o while valid_o=1, 0 otherwise.
busy_o  output  1  1 when valid_o=1 and ready_i=0 (stall indicator, combinational).

Behaviour:
- Reset (rst_ni=0, asynchronous): valid_o=0, idx_o=0, onehot_o=0, top=N-1. top is the internal highest-priority index register.
- Slot free: free = !valid_o || ready_i.
- Capture: on a rising edge with enable_i=1, free=1 and req_i!=0:
  - the winner is registered into idx_o/onehot_o;
  - valid_o=1 from the next cycle (latency 1);
  - throughput is 1 grant/cycle while ready_i=1.
- Drain: on an edge with valid_o=1, ready_i=1 and no capture, valid_o<=0 and onehot_o<=0. idx_o keeps its last value.
- Stall: while valid_o=1 and ready_i=0, idx_o/onehot_o/valid_o hold stable regardless of req_i, enable_i or mode_i.
- Fixed mode (mode_i=0): winner = highest set index of req_i. top is not modified.
- Round-robin mode (mode_i=1):
  - search descends from top: top, top-1, ..., 0, N-1, ..., top+1 (mod N); first set bit wins;
  - on each capture of winner k, top <= (k==0) ? N-1 : k-1.
- Mode switch: takes effect at the next capture. top keeps its value across switches, so RR resumes from the stored pointer.
- enable_i=0: no captures. A pending valid output is still presented and drained normally; it is never dropped.
- req_i==0 with free=1: no capture; valid_o falls per the drain rule. top is unchanged.
- Simultaneous drain and capture (valid_o=1, ready_i=1, new req): the new grant replaces the old in the same edge, and valid_o stays 1.
- Reset mid-stall: an outstanding grant is discarded and all state returns to reset values immediately.
- No X propagation: idx_o/onehot_o are defined for every req_i value.

Test Plan:
- Fixed mode, N=8, enable_i=1, ready_i=1. Apply req_i=8'hFF, 7F, 3F, 1F, 0F, 07, 03, 01, 00 one per cycle -> idx_o=7,6,5,4,3,2,1,0 one cycle after each, valid_o=1. After 00, valid_o=0 and onehot_o=0.
- Round-robin, req_i=8'hFF held, ready_i=1 -> idx_o sequence 7,6,5,4,3,2,1,0,7. With req_i=8'h81 held -> 7,0,7,0.
- Stall: capture req_i=8'h10 (idx_o=4), then ready_i=0 for 3 cycles while req_i=8'hFF -> idx_o=4, busy_o=1, valid_o=1 held. Raise ready_i -> next idx_o=7 (fixed mode).
- enable_i=0 with req_i=8'h0F -> valid_o stays 0. Enable_i dropped while a grant is pending with ready_i=0 -> grant held, then drained when ready_i=1.
- Reset mid-operation: RR mode after grants 7,6 (top=5), assert rst_ni=0 between clock edges -> valid_o=0 and onehot_o=0 immediately. After release, req_i=8'hFF -> idx_o=7.
- N=5 instance, RR, req_i=5'b10101 -> idx_o=4,2,0,4 (checks non-power-of-two wrap).

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder with fixed (MSB-first) or round-robin priority.
// Latency 1 cycle; valid/ready output slot that holds its grant while ready is low.
module prio_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic         mode_i,
  input  logic [N-1:0] req_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic         busy_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;
  logic [W-1:0] top_q;

  logic [W-1:0] fixed_win;
  logic [W-1:0] rr_win;
  logic [W-1:0] rr_pos;
  logic         rr_found;
  logic [W-1:0] win;
  logic [W-1:0] next_top;
  logic         free;
  logic         capture;

  always_comb begin
    fixed_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) fixed_win = W'(i);
    end
  end

  // Walk down from top with explicit wrap so non-power-of-two N never leaves 0..N-1.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_pos   = top_q;
    for (int i = 0; i < N; i++) begin
      if (!rr_found && req_i[rr_pos]) begin
        rr_win   = rr_pos;
        rr_found = 1'b1;
      end
      rr_pos = (rr_pos == '0) ? LAST : rr_pos - 1'b1;
    end
  end

  assign win      = mode_i ? rr_win : fixed_win;
  assign next_top = (win == '0) ? LAST : win - 1'b1;
  assign free     = !valid_q || ready_i;
  assign capture  = enable_i && free && (req_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      top_q    <= LAST;
    end else if (capture) begin
      valid_q  <= 1'b1;
      idx_q    <= win;
      onehot_q <= ONE << win;
      if (mode_i) top_q <= next_top;
    end else if (valid_q && ready_i) begin
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end
  end

  assign valid_o  = valid_q;
  assign idx_o    = idx_q;
  assign onehot_o = onehot_q;
  assign busy_o   = valid_q && !ready_i;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: vector table plus stall/enable/reset/N=5 sequences.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       rdy;
  logic [7:0] req;
  logic [4:0] req5;
  logic       vld, busy, vld5, busy5;
  logic [2:0] idx, idx5;
  logic [7:0] oh;
  logic [4:0] oh5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .mode_i(mode), .req_i(req),
    .ready_i(rdy), .valid_o(vld), .idx_o(idx), .onehot_o(oh), .busy_o(busy)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .mode_i(mode), .req_i(req5),
    .ready_i(rdy), .valid_o(vld5), .idx_o(idx5), .onehot_o(oh5), .busy_o(busy5)
  );

  typedef struct {
    bit         do_rst;
    bit         mode;
    logic [7:0] req;
    bit         exp_vld;
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
  } vec_t;

  vec_t vec[22];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input bit r, input bit m, input logic [7:0] q,
                         input bit v, input logic [2:0] x, input logic [7:0] o);
    vec[i].do_rst  = r;
    vec[i].mode    = m;
    vec[i].req     = q;
    vec[i].exp_vld = v;
    vec[i].exp_idx = x;
    vec[i].exp_oh  = o;
  endtask

  initial begin
    // Fixed priority walk-down, ending with an empty request.
    set_vec(0, 1, 0, 8'hFF, 1, 3'd7, 8'h80);
    set_vec(1, 0, 0, 8'h7F, 1, 3'd6, 8'h40);
    set_vec(2, 0, 0, 8'h3F, 1, 3'd5, 8'h20);
    set_vec(3, 0, 0, 8'h1F, 1, 3'd4, 8'h10);
    set_vec(4, 0, 0, 8'h0F, 1, 3'd3, 8'h08);
    set_vec(5, 0, 0, 8'h07, 1, 3'd2, 8'h04);
    set_vec(6, 0, 0, 8'h03, 1, 3'd1, 8'h02);
    set_vec(7, 0, 0, 8'h01, 1, 3'd0, 8'h01);
    set_vec(8, 0, 0, 8'h00, 0, 3'd0, 8'h00);
    // Round-robin with all requests held, rotating from top=7.
    set_vec(9,  1, 1, 8'hFF, 1, 3'd7, 8'h80);
    set_vec(10, 0, 1, 8'hFF, 1, 3'd6, 8'h40);
    set_vec(11, 0, 1, 8'hFF, 1, 3'd5, 8'h20);
    set_vec(12, 0, 1, 8'hFF, 1, 3'd4, 8'h10);
    set_vec(13, 0, 1, 8'hFF, 1, 3'd3, 8'h08);
    set_vec(14, 0, 1, 8'hFF, 1, 3'd2, 8'h04);
    set_vec(15, 0, 1, 8'hFF, 1, 3'd1, 8'h02);
    set_vec(16, 0, 1, 8'hFF, 1, 3'd0, 8'h01);
    set_vec(17, 0, 1, 8'hFF, 1, 3'd7, 8'h80);
    // Round-robin alternating between the two end sources.
    set_vec(18, 1, 1, 8'h81, 1, 3'd7, 8'h80);
    set_vec(19, 0, 1, 8'h81, 1, 3'd0, 8'h01);
    set_vec(20, 0, 1, 8'h81, 1, 3'd7, 8'h80);
    set_vec(21, 0, 1, 8'h81, 1, 3'd0, 8'h01);

    rst_n = 1'b0; en = 1'b1; mode = 1'b0; rdy = 1'b1; req = '0; req5 = '0;
    #12;
    check("reset_valid", vld, 0);
    check("reset_idx", idx, 0);
    check("reset_onehot", oh, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      if (vec[i].do_rst) begin
        req = '0;
        do_reset();
      end
      mode = vec[i].mode;
      req  = vec[i].req;
      step();
      check($sformatf("vec%0d_valid", i), vld, vec[i].exp_vld);
      check($sformatf("vec%0d_idx", i), idx, vec[i].exp_idx);
      check($sformatf("vec%0d_onehot", i), oh, vec[i].exp_oh);
    end

    // Stall: grant 4 must hold while ready is low and requests change.
    mode = 1'b0; req = '0; rdy = 1'b1;
    do_reset();
    req = 8'h10;
    step();
    check("stall_cap_idx", idx, 4);
    rdy = 1'b0; req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_idx", c), idx, 4);
      check($sformatf("stall%0d_onehot", c), oh, 8'h10);
      check($sformatf("stall%0d_valid", c), vld, 1);
      check($sformatf("stall%0d_busy", c), busy, 1);
    end
    rdy = 1'b1;
    #1;
    check("stall_release_busy", busy, 0);
    step();
    check("stall_after_idx", idx, 7);
    check("stall_after_valid", vld, 1);

    // Enable low blocks captures but never drops a pending grant.
    req = '0;
    do_reset();
    en = 1'b0; req = 8'h0F;
    step();
    step();
    check("en_off_valid", vld, 0);
    en = 1'b1; rdy = 1'b0;
    step();
    check("en_cap_idx", idx, 3);
    check("en_cap_valid", vld, 1);
    en = 1'b0;
    step();
    step();
    check("en_hold_idx", idx, 3);
    check("en_hold_valid", vld, 1);
    check("en_hold_busy", busy, 1);
    rdy = 1'b1;
    step();
    check("en_drain_valid", vld, 0);
    check("en_drain_onehot", oh, 0);
    check("en_drain_idx", idx, 3);
    en = 1'b1;

    // Asynchronous reset mid-run must also restore the RR pointer.
    req = '0; mode = 1'b1;
    do_reset();
    req = 8'hFF;
    step();
    check("rst_rr_first", idx, 7);
    step();
    check("rst_rr_second", idx, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", vld, 0);
    check("rst_async_onehot", oh, 0);
    check("rst_async_idx", idx, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("rst_after_idx", idx, 7);
    check("rst_after_valid", vld, 1);

    // N=5 round-robin wrap across a non-power-of-two width.
    req = '0; req5 = '0;
    do_reset();
    req5 = 5'b10101;
    step();
    check("n5_0_idx", idx5, 4);
    check("n5_0_onehot", oh5, 5'b10000);
    step();
    check("n5_1_idx", idx5, 2);
    step();
    check("n5_2_idx", idx5, 0);
    check("n5_2_onehot", oh5, 5'b00001);
    step();
    check("n5_3_idx", idx5, 4);
    check("n5_3_valid", vld5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
